wave_measure: RTL and testbench

Waveform measurement sink for the wave generator output. Consumes the signed 16-bit sample stream produced by the generator's compute stage, locks to rising zero crossings with hysteresis, and measures one full period: sample count, peak, trough and optionally amplitude/DC offset. It sits on the generator's `result` bus and closes the loop for self-test and calibration of `amp` and `phaseadd` settings.

---
 rtl/wave_measure_if.sv | 27 ++
 rtl/wave_measure.sv | 146 ++++++++++++++
 tb/tb_wave_measure.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wave_measure_if.sv
// Sample/control/result bundle between a stimulus source and wave_measure.
interface wave_measure_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 20
);
    logic signed [WIDTH-1:0] sample;
    logic                    sample_valid;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [CNT_W-1:0]        period;
    logic signed [WIDTH-1:0] peak;
    logic signed [WIDTH-1:0] trough;
    logic [WIDTH-1:0]        amp;
    logic signed [WIDTH-1:0] dc;

    modport master (
        output sample, sample_valid, start,
        input  busy, done, overflow, period, peak, trough, amp, dc
    );

    modport slave (
        input  sample, sample_valid, start,
        output busy, done, overflow, period, peak, trough, amp, dc
    );
endinterface

// File: rtl/wave_measure.sv
// Measures one full period of a signed sample stream between rising zero crossings.
// Define WAVE_MEASURE_DCOFF_EN to build the amp/dc arithmetic; otherwise both read 0.
module wave_measure #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 20,
    parameter int HYST  = 64
) (
    input  logic           clk,
    input  logic           reset,
    wave_measure_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, SYNC, MEASURE} state_t;

    localparam logic signed [WIDTH-1:0] NEG_HYST = WIDTH'(-HYST);

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [WIDTH-1:0] r_pk;
    logic signed [WIDTH-1:0] r_tr;
    logic                    r_arm;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;
    logic [CNT_W-1:0]        r_period;
    logic signed [WIDTH-1:0] r_peak;
    logic signed [WIDTH-1:0] r_trough;

    logic w_arming;
    logic w_cross;
    logic w_sat;
    logic w_end;

    assign w_arming = bus.sample_valid && (bus.sample <= NEG_HYST);
    assign w_cross  = bus.sample_valid && r_arm && !bus.sample[WIDTH-1];
    // The crossing wins over saturation when both would apply.
    assign w_sat    = bus.sample_valid && !w_cross && (&r_cnt);
    assign w_end    = (r_state == MEASURE) && (w_cross || w_sat);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pk       <= '0;
            r_tr       <= '0;
            r_arm      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_period   <= '0;
            r_peak     <= '0;
            r_trough   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (w_arming) begin
                        r_arm   <= 1'b1;
                        r_state <= SYNC;
                    end else if (w_cross) begin
                        r_arm <= 1'b0;
                    end
                end
                SYNC: begin
                    if (w_cross) begin
                        r_cnt   <= CNT_W'(1);
                        r_pk    <= bus.sample;
                        r_tr    <= bus.sample;
                        r_arm   <= 1'b0;
                        r_state <= MEASURE;
                    end else if (w_arming) begin
                        r_arm <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (w_end) begin
                        // Results come from the running extremes; the ending sample is excluded.
                        r_period   <= w_cross ? r_cnt : '1;
                        r_overflow <= w_sat;
                        r_peak     <= r_pk;
                        r_trough   <= r_tr;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                        if (w_cross) begin
                            r_arm <= 1'b0;
                        end
                    end else if (bus.sample_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (bus.sample > r_pk) begin
                            r_pk <= bus.sample;
                        end
                        if (bus.sample < r_tr) begin
                            r_tr <= bus.sample;
                        end
                        if (w_arming) begin
                            r_arm <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.period   = r_period;
    assign bus.peak     = r_peak;
    assign bus.trough   = r_trough;

`ifdef WAVE_MEASURE_DCOFF_EN
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] r_amp;
    logic [WIDTH-1:0] r_dc;

    // One extra bit so full-scale peak/trough cannot wrap before the halving.
    assign w_diff = {r_pk[WIDTH-1], r_pk} - {r_tr[WIDTH-1], r_tr};
    assign w_sum  = {r_pk[WIDTH-1], r_pk} + {r_tr[WIDTH-1], r_tr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_amp <= '0;
            r_dc  <= '0;
        end else if (w_end) begin
            r_amp <= w_diff[WIDTH:1];
            r_dc  <= w_sum[WIDTH:1];
        end
    end

    assign bus.amp = r_amp;
    assign bus.dc  = r_dc;
`else
    assign bus.amp = '0;
    assign bus.dc  = '0;
`endif
endmodule

// File: tb/tb_wave_measure.sv
// Scoreboard bench for wave_measure: a 20-bit counter instance and a 4-bit one for saturation.
module tb_wave_measure;
    typedef struct {
        logic [31:0] period;
        logic [15:0] peak;
        logic [15:0] trough;
        logic [15:0] amp;
        logic [15:0] dc;
        logic        ovf;
        int unsigned done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] drv_sample;
    logic        drv_valid;
    logic        drv_start;
    logic        sel;
    int unsigned cyc = 0;
    int unsigned last_cyc;
    int          checks = 0;
    int          failures = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea;
    exp_t        eb;

    int basic[10] = '{-200, 0, 300, 500, 300, -100, -300, -500, -300, 0};
    int gen[8]    = '{0, 23169, 32767, 23169, 0, -23169, -32767, -23169};

    wave_measure_if #(.WIDTH(16), .CNT_W(20)) bus_a ();
    wave_measure_if #(.WIDTH(16), .CNT_W(4))  bus_b ();

    wave_measure #(.WIDTH(16), .CNT_W(20), .HYST(64)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    wave_measure #(.WIDTH(16), .CNT_W(4), .HYST(64)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    assign bus_a.sample       = drv_sample;
    assign bus_a.sample_valid = drv_valid && !sel;
    assign bus_a.start        = drv_start && !sel;
    assign bus_b.sample       = drv_sample;
    assign bus_b.sample_valid = drv_valid && sel;
    assign bus_b.start        = drv_start && sel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        drv_start = 1'b1;
        drv_valid = 1'b0;
    endtask

    task automatic drive(input int s, input bit v);
        @(negedge clk);
        drv_start  = 1'b0;
        drv_sample = 16'(s);
        drv_valid  = v;
        last_cyc   = cyc;
    endtask

    task automatic push(input bit to_b, input int period, input int peak, input int trough,
                        input int amp, input int dc, input bit ovf);
        exp_t e;
        e.period = 32'(period);
        e.peak   = 16'(peak);
        e.trough = 16'(trough);
        e.amp    = 16'(amp);
        e.dc     = 16'(dc);
`ifndef WAVE_MEASURE_DCOFF_EN
        e.amp    = 16'h0;
        e.dc     = 16'h0;
`endif
        e.ovf      = ovf;
        e.done_cyc = last_cyc + 1;
        if (to_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    task automatic run_basic(input bit gaps);
        do_start();
        foreach (basic[i]) begin
            if (gaps) drive(0, 1'b0);
            drive(basic[i], 1'b1);
        end
        push(1'b0, 8, 500, -500, 500, 0, 1'b0);
        repeat (3) drive(0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (bus_a.done) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                ea = q_a.pop_front();
                check("a_period", {12'h0, bus_a.period}, ea.period);
                check("a_peak", {16'h0, bus_a.peak}, {16'h0, ea.peak});
                check("a_trough", {16'h0, bus_a.trough}, {16'h0, ea.trough});
                check("a_amp", {16'h0, bus_a.amp}, {16'h0, ea.amp});
                check("a_dc", {16'h0, bus_a.dc}, {16'h0, ea.dc});
                check("a_overflow", {31'h0, bus_a.overflow}, {31'h0, ea.ovf});
                check("a_busy_in_done", {31'h0, bus_a.busy}, 32'h0);
                check("a_done_cycle", cyc, ea.done_cyc);
            end
        end
        if (bus_b.done) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                eb = q_b.pop_front();
                check("b_period", {28'h0, bus_b.period}, eb.period);
                check("b_peak", {16'h0, bus_b.peak}, {16'h0, eb.peak});
                check("b_trough", {16'h0, bus_b.trough}, {16'h0, eb.trough});
                check("b_amp", {16'h0, bus_b.amp}, {16'h0, eb.amp});
                check("b_dc", {16'h0, bus_b.dc}, {16'h0, eb.dc});
                check("b_overflow", {31'h0, bus_b.overflow}, {31'h0, eb.ovf});
                check("b_done_cycle", cyc, eb.done_cyc);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        drv_sample = '0;
        drv_valid  = 1'b0;
        drv_start  = 1'b0;
        sel        = 1'b0;
        last_cyc   = 0;
        #3;
        check("rst_a_busy", {31'h0, bus_a.busy}, 32'h0);
        check("rst_a_done", {31'h0, bus_a.done}, 32'h0);
        check("rst_a_period", {12'h0, bus_a.period}, 32'h0);
        check("rst_b_busy", {31'h0, bus_b.busy}, 32'h0);
        #20 rst_n = 1'b1;

        // Basic period, then the same waveform with alternate invalid cycles.
        run_basic(1'b0);
        run_basic(1'b1);

        // Hysteresis: small swings never arm, so the block stays busy.
        do_start();
        for (int i = 0; i < 100; i++) drive((i % 2) ? -50 : 50, 1'b1);
        drive(0, 1'b0);
        check("hyst_busy", {31'h0, bus_a.busy}, 32'h1);
        foreach (basic[i]) drive(basic[i], 1'b1);
        push(1'b0, 8, 500, -500, 500, 0, 1'b0);
        repeat (3) drive(0, 1'b0);

        // Eight-step sine at full scale, measured twice.
        repeat (2) begin
            do_start();
            for (int i = 0; i <= 16; i++) drive(gen[i % 8], 1'b1);
            push(1'b0, 8, 32767, -32767, 32767, 0, 1'b0);
            repeat (3) drive(0, 1'b0);
        end

        // Saturation on the 4-bit counter instance.
        sel = 1'b1;
        do_start();
        drive(-200, 1'b1);
        drive(0, 1'b1);
        for (int i = 0; i < 15; i++) drive(100, 1'b1);
        push(1'b1, 15, 100, 0, 50, 50, 1'b1);
        repeat (3) drive(0, 1'b0);
        sel = 1'b0;

        // Asynchronous reset in the middle of MEASURE.
        do_start();
        drive(-200, 1'b1);
        drive(0, 1'b1);
        drive(300, 1'b1);
        drive(500, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'h0, bus_a.busy}, 32'h0);
        check("mid_rst_period", {12'h0, bus_a.period}, 32'h0);
        check("mid_rst_peak", {16'h0, bus_a.peak}, 32'h0);
        check("mid_rst_trough", {16'h0, bus_a.trough}, 32'h0);
        check("mid_rst_b_overflow", {31'h0, bus_b.overflow}, 32'h0);
        @(negedge clk);
        drv_valid = 1'b0;
        rst_n = 1'b1;
        run_basic(1'b0);

        repeat (4) drive(0, 1'b0);
        check("a_pending", 32'(q_a.size()), 32'h0);
        check("b_pending", 32'(q_b.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
